// File: rtl/audio_dac_serializer_if.sv
// PCM frame handshake between a sample source and the DAC serialiser.
interface audio_dac_serializer_if #(
  parameter int DATA_W = 32
);
  // valid/ready: a frame moves on a clock edge where sample_valid && sample_ready;
  // the source holds sample_data stable while sample_valid && !sample_ready.
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// DAC-side serial audio: double-buffers one PCM frame and shifts it out MSB-first
// as I2S, left-justified or DSP/TDM, with a generated LRCK, all on falling BCLK.
module audio_dac_serializer #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 32,
  parameter int NUM_CH        = 2,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                  AUD_BCLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  audio_dac_serializer_if.slave smp,
  output logic                  AUD_DACDAT,
  output logic                  AUD_DACLRCK,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt,
  output logic                  fsm_state
);

  localparam int FRAME_LEN = NUM_CH * SLOT_W;
  localparam int DATA_W    = NUM_CH * SAMPLE_W;
  localparam int FW        = $clog2(FRAME_LEN + 1);
  localparam int BW        = $clog2(SLOT_W + 1);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] SLOT_LIM   = FW'(SLOT_W);
  localparam logic [BW-1:0] SLOT_LAST  = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] SAMPLE_LIM = BW'(SAMPLE_W);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_n;
  logic [FW-1:0]       fcnt, fcnt_n;
  logic [BW-1:0]       bcnt, bcnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [DATA_W-1:0]   hold_buf;
  logic [DATA_W-1:0]   last_frame;
  logic                buf_full;
  logic [1:0]          mode_q, mode_n;
  logic                lj_q, lj_n;
  logic                load;
  logic                xfer;
  logic                dat_n, lrck_n, fs_n;

  assign smp.sample_ready = !buf_full && !reset;
  assign xfer             = smp.sample_valid && smp.sample_ready;
  assign fsm_state        = (state == RUN);

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    mode_n  = mode_q;
    load    = 1'b0;
    lj_n    = 1'b0;
    dat_n   = 1'b0;
    lrck_n  = 1'b0;
    fs_n    = 1'b0;

    case (state)
      IDLE: begin
        fcnt_n = '0;
        bcnt_n = '0;
        if (enable) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (fcnt == FRAME_LAST) begin
          fcnt_n = '0;
          bcnt_n = '0;
          if (enable) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
          end
        end else begin
          fcnt_n = fcnt + FW'(1);
          bcnt_n = (bcnt == SLOT_LAST) ? '0 : bcnt + BW'(1);
          // Only sample bits consume the register; slot padding leaves it parked.
          if (bcnt < SAMPLE_LIM) begin
            shreg_n = shreg << 1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      mode_n = mode;
      if (buf_full) begin
        shreg_n = hold_buf;
      end else if (UNDERRUN_HOLD != 0) begin
        shreg_n = last_frame;
      end else begin
        shreg_n = '0;
      end
    end

    if (state_n == RUN) begin
      lj_n = (bcnt_n < SAMPLE_LIM) ? shreg_n[DATA_W-1] : 1'b0;
      fs_n = (fcnt_n == '0);
      case (mode_n)
        2'd0: begin
          // I2S runs one bit behind the left-justified stream.
          dat_n  = lj_q;
          lrck_n = (fcnt_n >= SLOT_LIM);
        end
        2'd2: begin
          dat_n  = lj_n;
          lrck_n = (fcnt_n == '0);
        end
        default: begin
          dat_n  = lj_n;
          lrck_n = (fcnt_n < SLOT_LIM);
        end
      endcase
    end
  end

  always_ff @(negedge AUD_BCLK) begin
    if (reset) begin
      state        <= IDLE;
      fcnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      hold_buf     <= '0;
      last_frame   <= '0;
      buf_full     <= 1'b0;
      mode_q       <= 2'd0;
      lj_q         <= 1'b0;
      AUD_DACDAT   <= 1'b0;
      AUD_DACLRCK  <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      bcnt        <= bcnt_n;
      shreg       <= shreg_n;
      mode_q      <= mode_n;
      lj_q        <= lj_n;
      AUD_DACDAT  <= dat_n;
      AUD_DACLRCK <= lrck_n;
      frame_start <= fs_n;
      underrun    <= load && !buf_full;
      if (load && !buf_full && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      // Ready is low whenever the buffer is full, so a drain and a fill never coincide.
      if (load && buf_full) begin
        last_frame <= hold_buf;
        buf_full   <= 1'b0;
      end else if (xfer) begin
        hold_buf <= smp.sample_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: a 2-channel zero-fill instance and a
// 4-channel TDM repeat-on-underrun instance share one BCLK and reset.
module tb_audio_dac_serializer;

  logic        clk;
  logic        reset;
  logic        en_a, en_b;
  logic [1:0]  mode_a, mode_b;
  logic        dat_a, lrck_a, fs_a, und_a, st_a;
  logic        dat_b, lrck_b, fs_b, und_b, st_b;
  logic [15:0] cnt_a, cnt_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  audio_dac_serializer_if #(.DATA_W(32)) bus_a();
  audio_dac_serializer_if #(.DATA_W(64)) bus_b();

  audio_dac_serializer #(.SAMPLE_W(16), .SLOT_W(32), .NUM_CH(2), .UNDERRUN_HOLD(0)) dut_a (
    .AUD_BCLK(clk), .reset(reset), .enable(en_a), .mode(mode_a), .smp(bus_a.slave),
    .AUD_DACDAT(dat_a), .AUD_DACLRCK(lrck_a), .frame_start(fs_a), .underrun(und_a),
    .underrun_cnt(cnt_a), .fsm_state(st_a)
  );

  audio_dac_serializer #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(4), .UNDERRUN_HOLD(1)) dut_b (
    .AUD_BCLK(clk), .reset(reset), .enable(en_b), .mode(mode_b), .smp(bus_b.slave),
    .AUD_DACDAT(dat_b), .AUD_DACLRCK(lrck_b), .frame_start(fs_b), .underrun(und_b),
    .underrun_cnt(cnt_b), .fsm_state(st_b)
  );

  // Clock / reset: registers move on negedge, the bench samples and drives on posedge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        sel;
    logic [1:0]  mode;
    logic [63:0] data;
    logic [63:0] exp_dat;
    logic [63:0] exp_lrck;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_en(input logic sel, input logic v);
    if (sel) en_b = v;
    else     en_a = v;
  endtask

  task automatic push(input logic sel, input logic [1:0] m, input logic [63:0] d);
    if (sel) begin
      check("ready_before_push_b", 64'(bus_b.sample_ready), 64'd1);
      mode_b = m; bus_b.sample_data = d; bus_b.sample_valid = 1'b1;
    end else begin
      check("ready_before_push_a", 64'(bus_a.sample_ready), 64'd1);
      mode_a = m; bus_a.sample_data = d[31:0]; bus_a.sample_valid = 1'b1;
    end
    @(posedge clk);
    bus_a.sample_valid = 1'b0;
    bus_b.sample_valid = 1'b0;
  endtask

  task automatic start(input logic sel);
    set_en(sel, 1'b1);
    @(posedge clk);
  endtask

  // Records one 64-cycle frame; bit 63 of each word is cycle 0.
  task automatic capture(input logic sel, input int drop_at,
                         output logic [63:0] dat, output logic [63:0] lrck,
                         output logic [63:0] fs, output int pulses,
                         output logic [15:0] cnt0);
    pulses = 0;
    cnt0   = '0;
    dat    = '0;
    lrck   = '0;
    fs     = '0;
    for (int k = 0; k < 64; k++) begin
      dat[63-k]  = sel ? dat_b  : dat_a;
      lrck[63-k] = sel ? lrck_b : lrck_a;
      fs[63-k]   = sel ? fs_b   : fs_a;
      if (sel ? und_b : und_a) pulses++;
      if (k == 0) cnt0 = sel ? cnt_b : cnt_a;
      if (k == drop_at) set_en(sel, 1'b0);
      @(posedge clk);
    end
  endtask

  task automatic check_idle(input string name, input logic sel);
    if (sel) check(name, {61'd0, st_b, dat_b, lrck_b}, 64'd0);
    else     check(name, {61'd0, st_a, dat_a, lrck_a}, 64'd0);
  endtask

  initial begin
    logic [63:0] d, l, f, d1, exp1;
    logic [15:0] c0;
    int          p;

    vecs[0] = '{1'b0, 2'd1, 64'h0000_0000_A5C3_0F0F, 64'hA5C3_0000_0F0F_0000, 64'hFFFF_FFFF_0000_0000};
    vecs[1] = '{1'b0, 2'd0, 64'h0000_0000_A5C3_0F0F, 64'h52E1_8000_0787_8000, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{1'b0, 2'd3, 64'h0000_0000_8001_FFFF, 64'h8001_0000_FFFF_0000, 64'hFFFF_FFFF_0000_0000};
    vecs[3] = '{1'b0, 2'd0, 64'h0000_0000_FFFF_0001, 64'h7FFF_8000_0000_8000, 64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{1'b1, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000};
    vecs[5] = '{1'b1, 2'd2, 64'hFFFF_0000_8001_00FF, 64'hFFFF_0000_8001_00FF, 64'h8000_0000_0000_0000};

    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    bus_a.sample_valid = 1'b0; bus_a.sample_data = '0;
    bus_b.sample_valid = 1'b0; bus_b.sample_data = '0;

    // Reset held over three edges.
    repeat (3) @(posedge clk);
    check("rst_ready_a", 64'(bus_a.sample_ready), 64'd0);
    check("rst_ready_b", 64'(bus_b.sample_ready), 64'd0);
    check("rst_outs_a", {60'd0, dat_a, lrck_a, fs_a, und_a}, 64'd0);
    check("rst_cnt_a", 64'(cnt_a), 64'd0);
    check_idle("rst_idle_b", 1'b1);
    reset = 1'b0;
    @(posedge clk);
    check("post_rst_ready_a", 64'(bus_a.sample_ready), 64'd1);
    check("post_rst_ready_b", 64'(bus_b.sample_ready), 64'd1);
    check_idle("post_rst_idle_a", 1'b0);

    // Table: one buffered frame per vector, enable dropped in cycle 20.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].sel, vecs[i].mode, vecs[i].data);
      start(vecs[i].sel);
      capture(vecs[i].sel, 20, d, l, f, p, c0);
      exp_q.push_back(vecs[i].exp_dat);
      exp_q.push_back(vecs[i].exp_lrck);
      check($sformatf("v%0d_dat", i), d, exp_q.pop_front());
      check($sformatf("v%0d_lrck", i), l, exp_q.pop_front());
      check($sformatf("v%0d_fs", i), f, 64'h8000_0000_0000_0000);
      check($sformatf("v%0d_underrun", i), 64'(p), 64'd0);
      check_idle($sformatf("v%0d_idle", i), vecs[i].sel);
    end

    // Underrun: one frame pushed, enable held for three frames.
    for (int s = 0; s < 2; s++) begin
      logic sel;
      sel  = (s == 1);
      exp1 = sel ? 64'h1234_5678_9ABC_DEF0 : 64'hA5C3_0000_0F0F_0000;
      push(sel, sel ? 2'd2 : 2'd1, sel ? 64'h1234_5678_9ABC_DEF0 : 64'h0000_0000_A5C3_0F0F);
      start(sel);
      capture(sel, -1, d1, l, f, p, c0);
      check($sformatf("ur%0d_f1_dat", s), d1, exp1);
      check($sformatf("ur%0d_f1_pulses", s), 64'(p), 64'd0);
      capture(sel, -1, d, l, f, p, c0);
      check($sformatf("ur%0d_f2_dat", s), d, sel ? exp1 : 64'd0);
      check($sformatf("ur%0d_f2_pulses", s), 64'(p), 64'd1);
      check($sformatf("ur%0d_f2_cnt", s), 64'(c0), 64'd1);
      capture(sel, 20, d, l, f, p, c0);
      check($sformatf("ur%0d_f3_pulses", s), 64'(p), 64'd1);
      check($sformatf("ur%0d_f3_cnt", s), 64'(c0), 64'd2);
      check_idle($sformatf("ur%0d_idle", s), sel);
    end

    // Reset in cycle 40 with the holding buffer full.
    push(1'b0, 2'd1, 64'h0000_0000_A5C3_0F0F);
    start(1'b0);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        bus_a.sample_data = 32'h1357_2468;
        bus_a.sample_valid = 1'b1;
      end
      if (k == 11) bus_a.sample_valid = 1'b0;
      if (k == 20) check("midframe_ready_full", 64'(bus_a.sample_ready), 64'd0);
      @(posedge clk);
    end
    reset = 1'b1;
    en_a  = 1'b0;
    @(posedge clk);
    check("midrst_outs", {60'd0, dat_a, lrck_a, fs_a, st_a}, 64'd0);
    check("midrst_cnt", 64'(cnt_a), 64'd0);
    check("midrst_ready", 64'(bus_a.sample_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    check("after_midrst_ready", 64'(bus_a.sample_ready), 64'd1);
    check_idle("after_midrst_idle", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
